sent_rx_crc_arbiter: RTL and testbench

- Shares the single SENT RX CRC check engine between three requesters: fast-channel frame decode, short serial message decode and enhanced serial message decode.
- Arbitrates round-robin, issues the one-cycle CRC enable code, waits for the engine's done (or a timeout) and returns a per-requester done/result pulse.
- Sits between the pulse-check/decode front end and the CRC check block; keeps a saturating error count for status.

---
 rtl/sent_rx_crc_arbiter.sv | 147 ++++++++++++++
 tb/tb_sent_rx_crc_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sent_rx_crc_arbiter.sv
// Round-robin arbiter sharing one SENT RX CRC check engine between the fast-channel,
// short serial and enhanced serial decoders; tracks a saturating error count.
module sent_rx_crc_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ERR_CNT_W      = 8
) (
   input  logic                 clk_rx,
   input  logic                 reset_rx,
   input  logic                 req_fast_i,
   input  logic                 req_serial_i,
   input  logic                 req_enhanced_i,
   input  logic [2:0]           mode_fast_i,
   input  logic                 crc_check_done_i,
   input  logic                 crc_valid_i,
   output logic [2:0]           enable_crc_check_o,
   output logic [2:0]           grant_o,
   output logic [2:0]           done_o,
   output logic                 result_valid_o,
   output logic                 timeout_o,
   output logic                 busy_o,
   output logic [ERR_CNT_W-1:0] err_count_o
);

   localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state;
   logic [1:0]  ptr;
   logic [1:0]  gnt_idx;
   logic [2:0]  mode_q;
   logic [15:0] timer;

   logic [2:0]  req;
   logic        sel_vld;
   logic [1:0]  sel_idx;
   logic [2:0]  sel_code;

   function automatic logic mode_legal(input logic [2:0] m);
      return (m == 3'b001) || (m == 3'b010) || (m == 3'b011);
   endfunction

   assign req = {req_enhanced_i, req_serial_i, req_fast_i};

   // First requester at or after the pointer, order fast -> serial -> enhanced, wrapping.
   always_comb begin
      sel_vld = |req;
      sel_idx = 2'd0;
      unique case (ptr)
         2'd0: begin
            if (req[0])      sel_idx = 2'd0;
            else if (req[1]) sel_idx = 2'd1;
            else             sel_idx = 2'd2;
         end
         2'd1: begin
            if (req[1])      sel_idx = 2'd1;
            else if (req[2]) sel_idx = 2'd2;
            else             sel_idx = 2'd0;
         end
         default: begin
            if (req[2])      sel_idx = 2'd2;
            else if (req[0]) sel_idx = 2'd0;
            else             sel_idx = 2'd1;
         end
      endcase
   end

   always_comb begin
      sel_code = 3'b000;
      unique case (sel_idx)
         2'd0:    sel_code = mode_legal(mode_fast_i) ? mode_fast_i : 3'b000;
         2'd1:    sel_code = 3'b100;
         default: sel_code = 3'b101;
      endcase
   end

   // Timeout is combinational on done so that a same-cycle done suppresses it.
   assign timeout_o = (state == WAIT) && (timer == TMR_LAST) && !crc_check_done_i;
   assign busy_o    = (state != IDLE);

   always_ff @(posedge clk_rx) begin
      if (reset_rx) begin
         state              <= IDLE;
         ptr                <= 2'd0;
         gnt_idx            <= 2'd0;
         mode_q             <= 3'b000;
         timer              <= '0;
         enable_crc_check_o <= 3'b000;
         grant_o            <= 3'b000;
         done_o             <= 3'b000;
         result_valid_o     <= 1'b0;
         err_count_o        <= '0;
      end else begin
         enable_crc_check_o <= 3'b000;
         done_o             <= 3'b000;
         unique case (state)
            IDLE: begin
               if (sel_vld) begin
                  grant_o            <= 3'b001 << sel_idx;
                  gnt_idx            <= sel_idx;
                  enable_crc_check_o <= sel_code;
                  if (sel_idx == 2'd0) mode_q <= mode_fast_i;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if ((gnt_idx == 2'd0) && !mode_legal(mode_q)) begin
                  done_o         <= grant_o;
                  result_valid_o <= 1'b0;
                  state          <= RESP;
               end else begin
                  timer <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (crc_check_done_i) begin
                  done_o         <= grant_o;
                  result_valid_o <= crc_valid_i;
                  state          <= RESP;
               end else if (timer == TMR_LAST) begin
                  done_o         <= grant_o;
                  result_valid_o <= 1'b0;
                  state          <= RESP;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            RESP: begin
               if (!result_valid_o && (err_count_o != '1))
                  err_count_o <= err_count_o + 1'b1;
               ptr            <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
               grant_o        <= 3'b000;
               result_valid_o <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sent_rx_crc_arbiter.sv
// Directed bench for sent_rx_crc_arbiter: arbitration order, enable codes, bad mode,
// timeout, done/timeout collision, reset abort and error-count saturation.
module tb_sent_rx_crc_arbiter;

   logic       clk_rx = 1'b0;
   logic       reset_rx;
   logic       req_fast_i, req_serial_i, req_enhanced_i;
   logic [2:0] mode_fast_i;
   logic       crc_check_done_i, crc_valid_i;
   logic [2:0] enable_crc_check_o, grant_o, done_o;
   logic       result_valid_o, timeout_o, busy_o;
   logic [7:0] err_count_o;

   int vectors = 0;
   int miscompares = 0;

   sent_rx_crc_arbiter #(.TIMEOUT_CYCLES(4), .ERR_CNT_W(8)) dut (
      .clk_rx             (clk_rx),
      .reset_rx           (reset_rx),
      .req_fast_i         (req_fast_i),
      .req_serial_i       (req_serial_i),
      .req_enhanced_i     (req_enhanced_i),
      .mode_fast_i        (mode_fast_i),
      .crc_check_done_i   (crc_check_done_i),
      .crc_valid_i        (crc_valid_i),
      .enable_crc_check_o (enable_crc_check_o),
      .grant_o            (grant_o),
      .done_o             (done_o),
      .result_valid_o     (result_valid_o),
      .timeout_o          (timeout_o),
      .busy_o             (busy_o),
      .err_count_o        (err_count_o)
   );

   always #5 clk_rx = ~clk_rx;

   task automatic tick();
      @(posedge clk_rx);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " grant"},   grant_o, 3'b000);
      chk({tag, " enable"},  enable_crc_check_o, 3'b000);
      chk({tag, " done"},    done_o, 3'b000);
      chk({tag, " result"},  result_valid_o, 1'b0);
      chk({tag, " timeout"}, timeout_o, 1'b0);
      chk({tag, " busy"},    busy_o, 1'b0);
   endtask

   logic [2:0] exp_grant [4];
   logic [2:0] exp_en    [4];

   initial begin
      reset_rx = 1'b1;
      req_fast_i = 1'b0; req_serial_i = 1'b0; req_enhanced_i = 1'b0;
      mode_fast_i = 3'b000; crc_check_done_i = 1'b0; crc_valid_i = 1'b0;
      tick(); tick();
      chk_quiet("reset");
      chk("reset err", err_count_o, 8'd0);
      reset_rx = 1'b0;

      // Serial request, engine answers three cycles after enable
      req_serial_i = 1'b1;
      tick();
      chk("ser grant", grant_o, 3'b010);
      chk("ser enable", enable_crc_check_o, 3'b100);
      chk("ser busy", busy_o, 1'b1);
      tick();
      chk("ser enable one cycle", enable_crc_check_o, 3'b000);
      tick();
      tick();
      crc_check_done_i = 1'b1; crc_valid_i = 1'b1; req_serial_i = 1'b0;
      chk("ser no early done", done_o, 3'b000);
      tick();
      crc_check_done_i = 1'b0; crc_valid_i = 1'b0;
      chk("ser done", done_o, 3'b010);
      chk("ser result", result_valid_o, 1'b1);
      tick();
      chk_quiet("ser after");
      chk("ser err", err_count_o, 8'd0);

      // Round robin with all requests held
      reset_rx = 1'b1; tick(); reset_rx = 1'b0;
      req_fast_i = 1'b1; req_serial_i = 1'b1; req_enhanced_i = 1'b1;
      mode_fast_i = 3'b010;
      exp_grant[0] = 3'b001; exp_en[0] = 3'b010;
      exp_grant[1] = 3'b010; exp_en[1] = 3'b100;
      exp_grant[2] = 3'b100; exp_en[2] = 3'b101;
      exp_grant[3] = 3'b001; exp_en[3] = 3'b010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr grant", grant_o, exp_grant[i]);
         chk("rr enable", enable_crc_check_o, exp_en[i]);
         tick();
         tick();
         crc_check_done_i = 1'b1; crc_valid_i = 1'b1;
         tick();
         crc_check_done_i = 1'b0; crc_valid_i = 1'b0;
         chk("rr done", done_o, exp_grant[i]);
         chk("rr result", result_valid_o, 1'b1);
         tick();
         chk("rr grant idle", grant_o, 3'b000);
      end
      req_fast_i = 1'b0; req_serial_i = 1'b0; req_enhanced_i = 1'b0;
      chk("rr err", err_count_o, 8'd0);

      // Fast request with an illegal mode
      req_fast_i = 1'b1; mode_fast_i = 3'b000;
      tick();
      chk("bad grant", grant_o, 3'b001);
      chk("bad enable", enable_crc_check_o, 3'b000);
      req_fast_i = 1'b0;
      tick();
      chk("bad done", done_o, 3'b001);
      chk("bad result", result_valid_o, 1'b0);
      tick();
      chk_quiet("bad after");
      chk("bad err", err_count_o, 8'd1);

      // Enhanced request, engine silent -> timeout
      req_enhanced_i = 1'b1;
      tick();
      chk("to grant", grant_o, 3'b100);
      chk("to enable", enable_crc_check_o, 3'b101);
      req_enhanced_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("to early", timeout_o, 1'b0);
      end
      tick();
      chk("to pulse", timeout_o, 1'b1);
      chk("to no done yet", done_o, 3'b000);
      tick();
      chk("to done", done_o, 3'b100);
      chk("to result", result_valid_o, 1'b0);
      chk("to pulse one cycle", timeout_o, 1'b0);
      tick();
      chk_quiet("to after");
      chk("to err", err_count_o, 8'd2);
      req_serial_i = 1'b1;
      tick();
      chk("post-to grant", grant_o, 3'b010);
      chk("post-to enable", enable_crc_check_o, 3'b100);
      tick();
      crc_check_done_i = 1'b1; crc_valid_i = 1'b1; req_serial_i = 1'b0;
      tick();
      crc_check_done_i = 1'b0; crc_valid_i = 1'b0;
      chk("post-to done", done_o, 3'b010);
      chk("post-to result", result_valid_o, 1'b1);
      tick();
      chk("post-to err", err_count_o, 8'd2);

      // Done on the exact timeout cycle wins
      req_fast_i = 1'b1; mode_fast_i = 3'b011;
      tick();
      chk("edge grant", grant_o, 3'b001);
      chk("edge enable", enable_crc_check_o, 3'b011);
      req_fast_i = 1'b0;
      tick(); tick(); tick(); tick();
      crc_check_done_i = 1'b1; crc_valid_i = 1'b1;
      #1;
      chk("edge no timeout", timeout_o, 1'b0);
      tick();
      crc_check_done_i = 1'b0; crc_valid_i = 1'b0;
      chk("edge done", done_o, 3'b001);
      chk("edge result", result_valid_o, 1'b1);
      tick();
      chk("edge err", err_count_o, 8'd2);

      // Spurious done while idle
      crc_check_done_i = 1'b1; crc_valid_i = 1'b0;
      tick();
      crc_check_done_i = 1'b0;
      chk_quiet("spur");
      tick();
      chk_quiet("spur next");
      chk("spur err", err_count_o, 8'd2);

      // Reset during WAIT aborts silently
      req_serial_i = 1'b1;
      tick();
      req_serial_i = 1'b0;
      tick();
      chk("rst busy before", busy_o, 1'b1);
      reset_rx = 1'b1;
      tick();
      reset_rx = 1'b0;
      chk_quiet("rst mid");
      chk("rst err", err_count_o, 8'd0);
      tick();
      chk("rst no done", done_o, 3'b000);
      tick();
      chk("rst no done 2", done_o, 3'b000);

      // 256 back-to-back failures saturate the counter
      req_fast_i = 1'b1; mode_fast_i = 3'b111;
      for (int i = 0; i < 256; i++) begin
         tick();
         tick();
         chk("sat done", done_o, 3'b001);
         tick();
         chk("sat err", err_count_o, (i < 255) ? 32'(i + 1) : 32'd255);
      end
      req_fast_i = 1'b0;
      tick();
      tick();
      chk("sat hold", err_count_o, 8'd255);
      chk("sat idle", busy_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
